// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter in front of a shared register
//
// Lets N_REQ requesters share one WIDTH-bit register. The arbiter picks one
// pending request while IDLE, then spends exactly one GRANT cycle presenting
// the captured data with a load strobe and a one-hot acknowledge.
//
// Optional feature: define REG_WRITE_ARBITER_WRCNT_EN to add a 16-bit
// wrapping count of completed writes on wr_cnt_o.
//
// Ports:
//   clk_i     in   1            clock, rising edge
//   rst_i     in   1            asynchronous active-high reset
//   req_i     in   N_REQ        per-requester write request, held until gnt_o
//   data_i    in   N_REQ*WIDTH  write data, requester k at [k*WIDTH +: WIDTH]
//   gnt_o     out  N_REQ        one-hot acknowledge, one cycle per write
//   load_o    out  1            load strobe to the shared register
//   d_o       out  WIDTH        data to the shared register
//   busy_o    out  1            high during the GRANT cycle
//   wr_cnt_o  out  16           completed writes (REG_WRITE_ARBITER_WRCNT_EN only)

module reg_write_arbiter #(
   parameter int WIDTH = 16,
   parameter int N_REQ = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] data_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic                   load_o,
   output logic [WIDTH-1:0]       d_o,
   output logic                   busy_o
`ifdef REG_WRITE_ARBITER_WRCNT_EN
   ,
   output logic [15:0]            wr_cnt_o
`endif
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

   generate
      if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
         $error("reg_write_arbiter: N_REQ must be in 2..8");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;       // highest-priority index for the next search
   logic [PTR_W-1:0]   win_idx;   // winner held through GRANT for the ptr update

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic               win_found;
   logic [PTR_W:0]     win_off;
   logic [PTR_W-1:0]   win_sel;
   logic [WIDTH-1:0]   win_data;

   // (base + off) mod N_REQ; base < N_REQ and off <= N_REQ, so one
   // conditional subtract is enough.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W:0]   off);
      logic [PTR_W:0] sum;
      sum = {1'b0, base} + off;
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end
      return sum[PTR_W-1:0];
   endfunction

   // Rotate the request vector so bit 0 corresponds to ptr; the lowest set
   // bit of the rotated vector is then the first requester at or above ptr
   // (with wrap). The loop runs downward so the lowest hit wins.
   always_comb begin
      req_dbl   = {req_i, req_i};
      req_rot   = req_dbl[ptr +: N_REQ];
      win_found = 1'b0;
      win_off   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_found = 1'b1;
            win_off   = (PTR_W+1)'(i);
         end
      end
      win_sel  = wrap_add(ptr, win_off);
      win_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_sel == PTR_W'(k)) begin
            win_data = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   // Requests are only looked at in IDLE, so GRANT always lasts one cycle
   // and the best case is one write every two cycles. d_o is left alone
   // when returning to IDLE so it keeps the last captured value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ptr     <= '0;
         win_idx <= '0;
         gnt_o   <= '0;
         load_o  <= 1'b0;
         busy_o  <= 1'b0;
         d_o     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state   <= GRANT;
                  win_idx <= win_sel;
                  gnt_o   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_sel;
                  load_o  <= 1'b1;
                  busy_o  <= 1'b1;
                  d_o     <= win_data;
               end
            end
            GRANT: begin
               state  <= IDLE;
               ptr    <= wrap_add(win_idx, (PTR_W+1)'(1));
               gnt_o  <= '0;
               load_o <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef REG_WRITE_ARBITER_WRCNT_EN
   // Counted on the edge that completes GRANT, so a write aborted by reset
   // is not counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_cnt_o <= '0;
      end else if (state == GRANT) begin
         wr_cnt_o <= wr_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed table-driven bench for reg_write_arbiter

module tb_reg_write_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] data;
   logic [3:0]  gnt;
   logic        load;
   logic [15:0] d;
   logic        busy;
`ifdef REG_WRITE_ARBITER_WRCNT_EN
   logic [15:0] wr_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   reg_write_arbiter #(.WIDTH(16), .N_REQ(4)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .data_i  (data),
      .gnt_o   (gnt),
      .load_o  (load),
      .d_o     (d),
      .busy_o  (busy)
`ifdef REG_WRITE_ARBITER_WRCNT_EN
      ,
      .wr_cnt_o(wr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] data;
      logic [3:0]  gnt;
      logic        load;
      logic [15:0] d;
   } vec_t;

   vec_t vecs[9];
   logic [3:0] rr_gnt[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ptr walks 0 -> 3 -> 1 -> 2 -> 0 -> 1 -> 1 -> 2 -> 2 -> 3 across these
      vecs[0] = '{4'b0100, 64'h0000_1234_0000_0000, 4'b0100, 1'b1, 16'h1234};
      vecs[1] = '{4'b0011, 64'h1111_2222_3333_A0A0, 4'b0001, 1'b1, 16'hA0A0};
      vecs[2] = '{4'b0011, 64'h4444_5555_B1B1_6666, 4'b0010, 1'b1, 16'hB1B1};
      vecs[3] = '{4'b1001, 64'hC3C3_7777_8888_9999, 4'b1000, 1'b1, 16'hC3C3};
      vecs[4] = '{4'b1001, 64'h0F0F_1E1E_2D2D_D0D0, 4'b0001, 1'b1, 16'hD0D0};
      vecs[5] = '{4'b0001, 64'h0000_0000_0000_E0E0, 4'b0001, 1'b1, 16'hE0E0};
      vecs[6] = '{4'b1110, 64'hABCD_BCDE_F1F1_0000, 4'b0010, 1'b1, 16'hF1F1};
      vecs[7] = '{4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b0, 16'hF1F1};
      vecs[8] = '{4'b0101, 64'h1357_2468_9ABC_DEF0, 4'b0100, 1'b1, 16'h2468};

      rr_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

      rst  = 1'b1;
      req  = 4'b0000;
      data = 64'h0;
      #12;
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_load", load, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_d", d, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 9; v++) begin
         req  = vecs[v].req;
         data = vecs[v].data;
         tick();
         chk($sformatf("v%0d_gnt", v), gnt, vecs[v].gnt);
         chk($sformatf("v%0d_load", v), load, vecs[v].load);
         chk($sformatf("v%0d_busy", v), busy, vecs[v].load);
         chk($sformatf("v%0d_d", v), d, vecs[v].d);
         req = 4'b0000;
         tick();
         chk($sformatf("v%0d_idle_load", v), load, 1'b0);
         chk($sformatf("v%0d_idle_gnt", v), gnt, 4'b0000);
         chk($sformatf("v%0d_idle_d", v), d, vecs[v].d);
      end

      // ptr = 3: data change during GRANT, then req still high re-requests
      req  = 4'b0001;
      data = 64'h0000_0000_0000_AAAA;
      tick();
      chk("dc_gnt", gnt, 4'b0001);
      chk("dc_d_grant", d, 16'hAAAA);
      data = 64'h0000_0000_0000_5555;
      tick();
      chk("dc_d_hold", d, 16'hAAAA);
      chk("dc_idle_load", load, 1'b0);
      tick();
      chk("rereq_gnt", gnt, 4'b0001);
      chk("rereq_d", d, 16'h5555);
      req = 4'b0000;
      tick();

      // ptr = 1: reset in the middle of a GRANT cycle
      req  = 4'b0100;
      data = 64'h0000_7777_0000_0000;
      tick();
      chk("mr_gnt_before", gnt, 4'b0100);
      chk("mr_load_before", load, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_load", load, 1'b0);
      chk("mr_gnt", gnt, 4'b0000);
      chk("mr_busy", busy, 1'b0);
      chk("mr_d", d, 16'h0000);
      req  = 4'b1111;
      data = 64'h0D03_0D02_0D01_0D00;
      @(negedge clk);
      rst = 1'b0;

      // round robin from ptr 0 with all requests held
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("rr%0d_gnt", c + 1), gnt, rr_gnt[c]);
         chk($sformatf("rr%0d_load", c + 1), load, (rr_gnt[c] != 4'b0000));
      end
      req = 4'b0000;

      // ptr = 1: a request raised only during GRANT is not sampled
      req = 4'b1000;
      tick();
      chk("sg_gnt", gnt, 4'b1000);
      req = 4'b0001;
      tick();
      chk("sg_idle_gnt", gnt, 4'b0000);
      req = 4'b0000;
      tick();
      chk("sg_no_grant_gnt", gnt, 4'b0000);
      chk("sg_no_grant_load", load, 1'b0);

      // withdrawn before the edge: no side effect
      req = 4'b0010;
      @(negedge clk);
      req = 4'b0000;
      tick();
      chk("wd_load", load, 1'b0);
      chk("wd_gnt", gnt, 4'b0000);
      chk("wd_d", d, 16'h0D03);

`ifdef REG_WRITE_ARBITER_WRCNT_EN
      chk("wr_cnt", wr_cnt, 16'd6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, data width of the shared register.
REQ-002 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_i  input  N_REQ  per-requester write request, held until granted.
REQ-006 data_i  input  N_REQ*WIDTH  write data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-007 gnt_o  output  N_REQ  one-hot write acknowledge, high for exactly one cycle per granted write.
REQ-008 load_o  output  1  load strobe to the shared register's load input.
REQ-009 d_o  output  WIDTH  data to the shared register's data input.
REQ-010 busy_o  output  1  high while a write is in progress (GRANT state).

Function
REQ-011 FSM SHALL have two states: IDLE and GRANT.
REQ-012 IDLE: if req_i == 0, SHALL stay in IDLE; otherwise SHALL select one winner, capture its data_i into d_o, and go to GRANT on the next edge.
REQ-013 Winner SHALL be the first asserted req_i bit searching upward from index ptr, wrapping from N_REQ-1 to 0.
REQ-014 GRANT: load_o = 1, busy_o = 1, gnt_o = one-hot of winner, d_o = captured data, all for exactly one cycle; the FSM then returns to IDLE unconditionally.
REQ-015 On leaving GRANT, ptr SHALL become (winner+1) mod N_REQ, so the winner has lowest priority next time.
REQ-016 All outputs SHALL be registered; latency from req_i rising (in IDLE) to gnt_o/load_o SHALL be exactly 1 cycle.
REQ-017 Maximum throughput SHALL be one write per 2 cycles; no request SHALL be sampled during GRANT.
REQ-018 A requester SHALL hold req_i and its data_i stable until gnt_o; req_i still high in the IDLE cycle after gnt_o SHALL count as a new request.
REQ-019 Deassertion of req_i before grant SHALL withdraw the request with no side effect.
REQ-020 Changes to data_i during GRANT SHALL NOT affect d_o (captured value is used).
REQ-021 In IDLE, load_o = 0, gnt_o = 0, busy_o = 0, and d_o SHALL hold the last captured value.
REQ-022 Any single requester asserting continuously among N_REQ requesters SHALL be granted within 2*N_REQ cycles (starvation-free).

Reset
REQ-023 rst_i high SHALL immediately force IDLE, ptr = 0, gnt_o = 0, load_o = 0, busy_o = 0, d_o = 0, independent of clk_i.
REQ-024 Reset asserted during GRANT SHALL abort the write: load_o drops without waiting for an edge, and ptr is not advanced.
REQ-025 After rst_i is deasserted, the first edge SHALL evaluate req_i as in IDLE.

Configuration
REQ-026 Macro REG_WRITE_ARBITER_WRCNT_EN SHALL gate a write counter feature.
REQ-027 With it defined: an output wr_cnt_o (16 bits) SHALL increment on each GRANT cycle, wrap from 0xFFFF to 0x0000, and reset to 0.
REQ-028 Without it: wr_cnt_o and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Single: reset, req_i=4'b0100, data2=0x1234 -> next cycle gnt_o=4'b0100, load_o=1, d_o=0x1234; following cycle load_o=0.
REQ-030 Round-robin: req_i=4'b1111 held -> grants in order 0,1,2,3,0 on cycles 1,3,5,7,9 after reset.
REQ-031 Wrap: ptr=3 (after granting req 2), req_i=4'b0011 -> grant 0, then 1.
REQ-032 Data change: data0 changes 0xAAAA->0x5555 during GRANT -> d_o stays 0xAAAA.
REQ-033 Reset mid-GRANT: assert rst_i mid-cycle during GRANT -> load_o/gnt_o drop immediately, d_o=0, next grant starts from index 0.
REQ-034 With REG_WRITE_ARBITER_WRCNT_EN: 65537 grants -> wr_cnt_o=0x0001.
